adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares one `cla_adder_32bit` instance between `NUM_REQ` requesters. Each requester has a valid/ready operand channel. The arbiter registers the winning operands and drives the shared adder. It returns the sum, carry-out and requester ID on a single valid/ready response channel. The block sits between the ALU-side clients and the adder under comparison, so every adder architecture sees identical, registered stimulus.

---
 rtl/adder_share_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sequencer sharing one cla_adder_32bit among NUM_REQ requesters.
// Latency: operands accepted in IDLE, adder evaluated in EXEC, response presented from RESP (issue every 3 cycles).
// Backpressure: RESP holds the response until rsp_ready_i; no request is accepted until it is taken.
// Optional chaining is enabled by defining ADDER_ARB_CHAIN_EN (adds req_hold_i, lock and carry chaining).

module cla_adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // 4-bit group generate/propagate terms for the lookahead carry chain
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int grp = 0; grp < 8; grp++) begin
            grp_p[grp] = &p[grp*4 +: 4];
            grp_g[grp] = g[grp*4+3]
                       | (p[grp*4+3] & g[grp*4+2])
                       | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                       | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4]);
        end
    end

    // Group carries skip across groups; bit carries ripple only inside a group
    always_comb begin
        logic grp_c;
        logic bit_c;
        sum_o = '0;
        grp_c = cin_i;
        for (int grp = 0; grp < 8; grp++) begin
            bit_c = grp_c;
            for (int b = 0; b < 4; b++) begin
                sum_o[grp*4+b] = p[grp*4+b] ^ bit_c;
                bit_c = g[grp*4+b] | (p[grp*4+b] & bit_c);
            end
            grp_c = grp_g[grp] | (grp_p[grp] & grp_c);
        end
        cout_o = grp_c;
    end
endmodule

module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_a_i,
    input  logic [NUM_REQ*32-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]   req_cin_i,
`ifdef ADDER_ARB_CHAIN_EN
    input  logic [NUM_REQ-1:0]   req_hold_i,
`endif
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_sum_o,
    output logic                 rsp_cout_o,
    output logic [ID_W-1:0]      rsp_id_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic            op_cin_q, op_cin_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    logic [31:0]     sum_q, sum_d;
    logic            cout_q, cout_d;
    logic [ID_W-1:0] rid_q, rid_d;
`ifdef ADDER_ARB_CHAIN_EN
    logic            hold_q, hold_d;
    logic            lock_q, lock_d;
    logic            carry_q, carry_d;
`endif

    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] scan_id;
    logic            grant_cin;
    logic [31:0]     add_sum;
    logic            add_cout;

    cla_adder_32bit u_adder (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .cin_i  (op_cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Round-robin pick: scan downward from last+NUM_REQ so the closest requester after last wins
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan_id = ID_W'((int'(last_q) + i) % NUM_REQ);
            if (req_valid_i[scan_id]) begin
                grant_vld = 1'b1;
                grant_id  = scan_id;
            end
        end
        grant_cin = req_cin_i[grant_id];
`ifdef ADDER_ARB_CHAIN_EN
        // A locked chain belongs to its owner; its carry comes from the previous link
        if (lock_q) begin
            grant_vld = req_valid_i[last_q];
            grant_id  = last_q;
            grant_cin = carry_q;
        end
`endif
    end

    // Sequencer next-state, operand capture and response capture
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        rid_d       = rid_q;
`ifdef ADDER_ARB_CHAIN_EN
        hold_d      = hold_q;
        lock_d      = lock_q;
        carry_d     = carry_q;
`endif
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld && !rst_i) begin
                    req_ready_o[grant_id] = 1'b1;
                    op_a_d   = req_a_i[grant_id*32 +: 32];
                    op_b_d   = req_b_i[grant_id*32 +: 32];
                    op_cin_d = grant_cin;
                    op_id_d  = grant_id;
                    last_d   = grant_id;
`ifdef ADDER_ARB_CHAIN_EN
                    hold_d   = req_hold_i[grant_id];
`endif
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                sum_d   = add_sum;
                cout_d  = add_cout;
                rid_d   = op_id_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
`ifdef ADDER_ARB_CHAIN_EN
                    lock_d = hold_q;
                    if (hold_q) begin
                        carry_d = cout_q;
                    end
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_q   <= ID_W'(NUM_REQ - 1);
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            op_id_q  <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            rid_q    <= '0;
`ifdef ADDER_ARB_CHAIN_EN
            hold_q   <= 1'b0;
            lock_q   <= 1'b0;
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            op_id_q  <= op_id_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            rid_q    <= rid_d;
`ifdef ADDER_ARB_CHAIN_EN
            hold_q   <= hold_d;
            lock_q   <= lock_d;
            carry_q  <= carry_d;
`endif
        end
    end

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_sum_o   = sum_q;
    assign rsp_cout_o  = cout_q;
    assign rsp_id_o    = rid_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Inputs are driven just after the rising edge; outputs are compared on the falling edge.
// Define ADDER_ARB_CHAIN_EN to also exercise carry chaining.

module tb_adder_share_arbiter;
    localparam int N = 4;

    logic          clk;
    logic          rst_i;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready_o;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]  req_cin;
`ifdef ADDER_ARB_CHAIN_EN
    logic [N-1:0]  req_hold;
`endif
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_sum_o;
    logic          rsp_cout_o;
    logic [1:0]    rsp_id_o;

    adder_share_arbiter #(.NUM_REQ(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_cin_i   (req_cin),
`ifdef ADDER_ARB_CHAIN_EN
        .req_hold_i  (req_hold),
`endif
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_sum_o   (rsp_sum_o),
        .rsp_cout_o  (rsp_cout_o),
        .rsp_id_o    (rsp_id_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_bad;
    int cyc;
    int grant_log[$];
    int rsp_cyc[$];

    // Transaction model: phase 0 = free, 1 = computing, 2 = response offered
    int          m_phase;
    int          m_last;
    logic [31:0] m_sum;
    logic        m_cout;
    int          m_id;
    logic [31:0] m_psum;
    logic        m_pcout;
    int          m_pid;
    logic        m_phold;
    logic        m_lock;
    logic        m_carry;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] exp_rdy;
        logic [32:0]  full;
        logic         cin;
        int           win;
        exp_rdy = '0;
        win     = -1;
        if (!rst_i && m_phase == 0) begin
            if (m_lock) begin
                if (req_valid[m_last]) win = m_last;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    int k;
                    k = (m_last + i) % N;
                    if (req_valid[k] && win < 0) win = k;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
        end
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid_o), 64'(m_phase == 2));
        chk("rsp_sum",   64'(rsp_sum_o),   64'(m_sum));
        chk("rsp_cout",  64'(rsp_cout_o),  64'(m_cout));
        chk("rsp_id",    64'(rsp_id_o),    64'(m_id));

        if (!rst_i) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready_o[i]) grant_log.push_back(i);
            if (rsp_valid_o && rsp_ready_i) rsp_cyc.push_back(cyc);
        end

        if (rst_i) begin
            m_phase = 0; m_last = N - 1; m_sum = '0; m_cout = 1'b0; m_id = 0;
            m_lock = 1'b0; m_carry = 1'b0; m_phold = 1'b0;
        end else begin
            case (m_phase)
                0: if (win >= 0) begin
                    cin = m_lock ? m_carry : req_cin[win];
                    full = {1'b0, req_a[win*32 +: 32]} + {1'b0, req_b[win*32 +: 32]} + 33'(cin);
                    m_psum  = full[31:0];
                    m_pcout = full[32];
                    m_pid   = win;
`ifdef ADDER_ARB_CHAIN_EN
                    m_phold = req_hold[win];
`else
                    m_phold = 1'b0;
`endif
                    m_last  = win;
                    m_phase = 1;
                end
                1: begin
                    m_sum = m_psum; m_cout = m_pcout; m_id = m_pid; m_phase = 2;
                end
                default: if (rsp_ready_i) begin
                    m_phase = 0;
                    m_lock  = m_phold;
                    if (m_phold) m_carry = m_cout;
                end
            endcase
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic cin);
        req_a[k*32 +: 32] = a;
        req_b[k*32 +: 32] = b;
        req_cin[k]        = cin;
        req_valid[k]      = 1'b1;
    endtask

    task automatic wait_ready(input int k);
        int t;
        t = 0;
        #1;
        while (!req_ready_o[k] && t < 40) begin
            tick();
            t++;
        end
        chk($sformatf("wait_ready%0d", k), 64'(req_ready_o[k]), 64'd1);
    endtask

    // Accept requester k, then wait for its response; lat counts edges from accept cycle
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         output int lat);
        set_req(k, a, b, cin);
        wait_ready(k);
        tick();
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic rst_pulse();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_phase = 0; m_last = N - 1; m_sum = '0; m_cout = 1'b0; m_id = 0;
        m_psum = '0; m_pcout = 1'b0; m_pid = 0; m_phold = 1'b0; m_lock = 1'b0; m_carry = 1'b0;
        rst_i = 1'b1; rsp_ready_i = 1'b0;
        req_valid = '0; req_cin = '0; req_a = '0; req_b = '0;
`ifdef ADDER_ARB_CHAIN_EN
        req_hold = '0;
`endif
        fork
            forever begin
                @(negedge clk);
                model_step();
            end
        join_none

        // Reset state
        tick(); tick();
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_sum",   64'(rsp_sum_o),   64'd0);
        chk("rst_id",    64'(rsp_id_o),    64'd0);
        req_valid = '0;
        tick();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;

        // Single op
        do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, lat);
        chk("single_lat",  64'(lat), 64'd2);
        chk("single_sum",  64'(rsp_sum_o), 64'h8);
        chk("single_cout", 64'(rsp_cout_o), 64'd0);
        chk("single_id",   64'(rsp_id_o), 64'd0);
        tick();

        // Carry edge
        do_op(2, 32'hFFFF_FFFF, 32'h0, 1'b1, lat);
        chk("carry_sum",  64'(rsp_sum_o), 64'h0);
        chk("carry_cout", 64'(rsp_cout_o), 64'd1);
        chk("carry_id",   64'(rsp_id_o), 64'd2);
        tick();

        // Fairness: all requesters held valid
        rst_pulse();
        grant_log.delete();
        rsp_cyc.delete();
        for (int k = 0; k < N; k++) set_req(k, 32'(k * 16 + 1), 32'(k), 1'b0);
        repeat (14) tick();
        req_valid = '0;
        repeat (6) tick();
        chk("fair_count", 64'(grant_log.size() >= 5), 64'd1);
        chk("fair_g0", 64'(grant_log[0]), 64'd0);
        chk("fair_g1", 64'(grant_log[1]), 64'd1);
        chk("fair_g2", 64'(grant_log[2]), 64'd2);
        chk("fair_g3", 64'(grant_log[3]), 64'd3);
        chk("fair_g4", 64'(grant_log[4]), 64'd0);
        chk("fair_rsp_count", 64'(rsp_cyc.size() >= 4), 64'd1);
        for (int i = 1; i < 4; i++)
            chk($sformatf("fair_gap%0d", i), 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd3);

        // Backpressure
        rst_pulse();
        rsp_ready_i = 1'b0;
        set_req(1, 32'd100, 32'd23, 1'b0);
        set_req(3, 32'd7, 32'd8, 1'b0);
        wait_ready(1);
        chk("bp_first_grant", 64'(req_ready_o), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(rsp_valid_o), 64'd1);
            chk("bp_sum",   64'(rsp_sum_o), 64'd123);
            chk("bp_id",    64'(rsp_id_o), 64'd1);
            chk("bp_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        chk("bp_next_grant", 64'(req_ready_o), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_sum3", 64'(rsp_sum_o), 64'd15);
        chk("bp_id3",  64'(rsp_id_o), 64'd3);
        tick();

        // Reset during EXEC
        set_req(2, 32'h1234_0000, 32'h0000_5678, 1'b1);
        wait_ready(2);
        tick();
        req_valid = '0;
        chk("exec_valid", 64'(rsp_valid_o), 64'd0);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(rsp_valid_o), 64'd0);
        chk("mid_rst_sum",   64'(rsp_sum_o), 64'd0);
        chk("mid_rst_cout",  64'(rsp_cout_o), 64'd0);
        chk("mid_rst_id",    64'(rsp_id_o), 64'd0);
        chk("mid_rst_ready", 64'(req_ready_o), 64'd0);
        rst_i = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 32'(k), 32'd1, 1'b0);
        #1;
        chk("mid_rst_prio", 64'(req_ready_o), 64'b0001);
        tick();
        req_valid = '0;
        repeat (4) tick();
        chk("mid_rst_no_replay_sum", 64'(rsp_sum_o), 64'd1);

`ifdef ADDER_ARB_CHAIN_EN
        // Carry chaining: req3 must wait while req1 holds the adder
        rst_pulse();
        grant_log.delete();
        set_req(3, 32'h10, 32'h20, 1'b0);
        set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req_hold[1] = 1'b1;
        wait_ready(1);
        tick();
        req_valid[1] = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("chain1_sum",  64'(rsp_sum_o), 64'h0);
        chk("chain1_cout", 64'(rsp_cout_o), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("chain_locked_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        req_hold[1] = 1'b0;
        set_req(1, 32'h0, 32'h0, 1'b0);
        wait_ready(1);
        tick();
        req_valid[1] = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("chain2_sum",  64'(rsp_sum_o), 64'h1);
        chk("chain2_cout", 64'(rsp_cout_o), 64'd0);
        chk("chain2_id",   64'(rsp_id_o), 64'd1);
        tick();
        wait_ready(3);
        chk("chain_order_len", 64'(grant_log.size()), 64'd2);
        chk("chain_order0", 64'(grant_log[0]), 64'd1);
        chk("chain_order1", 64'(grant_log[1]), 64'd1);
        tick();
        req_valid[3] = 1'b0;
        repeat (4) tick();
        chk("chain_req3_sum", 64'(rsp_sum_o), 64'h30);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
